// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station: widths, opcode
// encodings, the per-entry storage layout and the result-bus snoop helper.
package alu_rs_pkg;

    localparam int REG_WIDTH        = 32;
    localparam int OPCODE_ALU_WIDTH = 4;
    // Tags are stored at this width so the entry layout is independent of ROB_WIDTH
    localparam int TAG_MAX_WIDTH    = 8;

    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_AND  = 4'd1;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_OR   = 4'd2;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_XOR  = 4'd3;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_ADD  = 4'd4;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SUB  = 4'd5;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLL  = 4'd8;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_LT   = 4'd9;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_LTU  = 4'd10;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_EQ   = 4'd11;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_NE   = 4'd12;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_GE   = 4'd13;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_GEU  = 4'd14;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_JALR = 4'd15;

    typedef struct packed {
        logic                     ready;
        logic [REG_WIDTH-1:0]     val;
        logic [TAG_MAX_WIDTH-1:0] tag;
    } rs_operand_t;

    typedef struct packed {
        logic                        valid;
        logic [OPCODE_ALU_WIDTH-1:0] opcode;
        rs_operand_t                 lhs;
        rs_operand_t                 rhs;
        logic [TAG_MAX_WIDTH-1:0]    dest_tag;
    } rs_entry_t;

    // A pending operand captures a matching broadcast; the ALU bus is checked first.
    function automatic rs_operand_t snoop_operand(
        input rs_operand_t              op,
        input logic                     alu_en,
        input logic [REG_WIDTH-1:0]     alu_val,
        input logic [TAG_MAX_WIDTH-1:0] alu_tag_v,
        input logic                     lsb_en,
        input logic [REG_WIDTH-1:0]     lsb_val,
        input logic [TAG_MAX_WIDTH-1:0] lsb_tag_v
    );
        rs_operand_t res;
        res = op;
        if (!op.ready && alu_en && (op.tag == alu_tag_v)) begin
            res.ready = 1'b1;
            res.val   = alu_val;
        end else if (!op.ready && lsb_en && (op.tag == lsb_tag_v)) begin
            res.ready = 1'b1;
            res.val   = lsb_val;
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_priority_enc.sv
// Find-first-set over 2**IDX_WIDTH request bits; lowest index wins.
module rs_priority_enc #(
    parameter int IDX_WIDTH = 3
) (
    input  logic [(1<<IDX_WIDTH)-1:0] req,
    output logic                      found,
    output logic [IDX_WIDTH-1:0]      index
);

    localparam int N = 1 << IDX_WIDTH;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            index = req[i] ? IDX_WIDTH'(i) : index;
        end
        found = |req;
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched operations until both operands
// are known, wakes them from the ALU/LSB result buses and issues one per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_signal,
    input  logic                        dispatch_valid,
    input  logic [OPCODE_ALU_WIDTH-1:0] dispatch_opcode,
    input  logic                        dispatch_lhs_ready,
    input  logic [REG_WIDTH-1:0]        dispatch_lhs_val,
    input  logic [ROB_WIDTH-1:0]        dispatch_lhs_tag,
    input  logic                        dispatch_rhs_ready,
    input  logic [REG_WIDTH-1:0]        dispatch_rhs_val,
    input  logic [ROB_WIDTH-1:0]        dispatch_rhs_tag,
    input  logic [ROB_WIDTH-1:0]        dispatch_tag,
    output logic                        rs_full,
    input  logic                        alu_done,
    input  logic [REG_WIDTH-1:0]        alu_result,
    input  logic [ROB_WIDTH-1:0]        alu_tag,
    input  logic                        lsb_done,
    input  logic [REG_WIDTH-1:0]        lsb_result,
    input  logic [ROB_WIDTH-1:0]        lsb_tag,
    output logic                        cal_signal,
    output logic [OPCODE_ALU_WIDTH-1:0] opcode,
    output logic [REG_WIDTH-1:0]        lhs,
    output logic [REG_WIDTH-1:0]        rhs,
    output logic [ROB_WIDTH-1:0]        tag
);

    localparam int RS_SIZE = 1 << RS_WIDTH;

    rs_entry_t                   entries_r     [RS_SIZE];
    rs_entry_t                   entries_nxt_s [RS_SIZE];
    rs_entry_t                   dispatch_entry_s;
    rs_operand_t                 disp_lhs_raw_s;
    rs_operand_t                 disp_rhs_raw_s;

    logic [RS_SIZE-1:0]          free_vec_s;
    logic [RS_SIZE-1:0]          ready_vec_s;
    logic                        free_found_s;
    logic [RS_WIDTH-1:0]         free_idx_s;
    logic                        issue_found_s;
    logic [RS_WIDTH-1:0]         issue_idx_s;
    logic                        rs_full_s;
    logic                        dispatch_we_s;

    logic [TAG_MAX_WIDTH-1:0]    alu_tag_ext_s;
    logic [TAG_MAX_WIDTH-1:0]    lsb_tag_ext_s;

    logic                        cal_r;
    logic [OPCODE_ALU_WIDTH-1:0] opcode_r;
    logic [REG_WIDTH-1:0]        lhs_r;
    logic [REG_WIDTH-1:0]        rhs_r;
    logic [ROB_WIDTH-1:0]        tag_r;

    assign alu_tag_ext_s = TAG_MAX_WIDTH'(alu_tag);
    assign lsb_tag_ext_s = TAG_MAX_WIDTH'(lsb_tag);

    // Free and issue-candidate vectors come only from registered state, so a
    // slot freed or woken this cycle is not visible until the next one.
    always_comb begin
        free_vec_s  = '0;
        ready_vec_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec_s[i]  = ~entries_r[i].valid;
            ready_vec_s[i] = entries_r[i].valid & entries_r[i].lhs.ready & entries_r[i].rhs.ready;
        end
    end

    rs_priority_enc #(.IDX_WIDTH(RS_WIDTH)) u_free_enc (
        .req   (free_vec_s),
        .found (free_found_s),
        .index (free_idx_s)
    );

    rs_priority_enc #(.IDX_WIDTH(RS_WIDTH)) u_issue_enc (
        .req   (ready_vec_s),
        .found (issue_found_s),
        .index (issue_idx_s)
    );

    assign rs_full_s     = ~free_found_s;
    assign rs_full       = rs_full_s;
    assign dispatch_we_s = dispatch_valid & ~rs_full_s;

    // Build the incoming entry, forwarding any same-cycle broadcast into it.
    always_comb begin
        disp_lhs_raw_s.ready = dispatch_lhs_ready;
        disp_lhs_raw_s.val   = dispatch_lhs_val;
        disp_lhs_raw_s.tag   = TAG_MAX_WIDTH'(dispatch_lhs_tag);
        disp_rhs_raw_s.ready = dispatch_rhs_ready;
        disp_rhs_raw_s.val   = dispatch_rhs_val;
        disp_rhs_raw_s.tag   = TAG_MAX_WIDTH'(dispatch_rhs_tag);

        dispatch_entry_s.valid    = 1'b1;
        dispatch_entry_s.opcode   = dispatch_opcode;
        dispatch_entry_s.lhs      = snoop_operand(disp_lhs_raw_s, alu_done, alu_result, alu_tag_ext_s,
                                                  lsb_done, lsb_result, lsb_tag_ext_s);
        dispatch_entry_s.rhs      = snoop_operand(disp_rhs_raw_s, alu_done, alu_result, alu_tag_ext_s,
                                                  lsb_done, lsb_result, lsb_tag_ext_s);
        dispatch_entry_s.dest_tag = TAG_MAX_WIDTH'(dispatch_tag);
    end

    // Entry next state: flush, else wakeup + issue-invalidate + dispatch write.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_nxt_s[i] = entries_r[i];
        end
        if (clear_signal) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_nxt_s[i].valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (dispatch_we_s && (free_idx_s == RS_WIDTH'(i))) begin
                    entries_nxt_s[i] = dispatch_entry_s;
                end else begin
                    entries_nxt_s[i].lhs   = snoop_operand(entries_r[i].lhs, alu_done, alu_result,
                                                           alu_tag_ext_s, lsb_done, lsb_result,
                                                           lsb_tag_ext_s);
                    entries_nxt_s[i].rhs   = snoop_operand(entries_r[i].rhs, alu_done, alu_result,
                                                           alu_tag_ext_s, lsb_done, lsb_result,
                                                           lsb_tag_ext_s);
                    entries_nxt_s[i].valid = entries_r[i].valid &
                                             ~(issue_found_s && (issue_idx_s == RS_WIDTH'(i)));
                end
            end
        end
    end

    // Entry storage; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_r[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_r[i] <= entries_nxt_s[i];
            end
        end
    end

    // Issue register: pulse per issued op, data holds when nothing issues.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cal_r    <= 1'b0;
            opcode_r <= '0;
            lhs_r    <= '0;
            rhs_r    <= '0;
            tag_r    <= '0;
        end else if (rdy_in) begin
            if (clear_signal) begin
                cal_r <= 1'b0;
            end else if (issue_found_s) begin
                cal_r    <= 1'b1;
                opcode_r <= entries_r[issue_idx_s].opcode;
                lhs_r    <= entries_r[issue_idx_s].lhs.val;
                rhs_r    <= entries_r[issue_idx_s].rhs.val;
                tag_r    <= ROB_WIDTH'(entries_r[issue_idx_s].dest_tag);
            end else begin
                cal_r <= 1'b0;
            end
        end
    end

    assign cal_signal = cal_r;
    assign opcode     = opcode_r;
    assign lhs        = lhs_r;
    assign rhs        = rhs_r;
    assign tag        = tag_r;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-array reference model predicts issues,
// a separate monitor compares every DUT issue and the held outputs.
module tb_alu_rs;

    localparam int RS_N = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_signal, dispatch_valid;
    logic [3:0]  dispatch_opcode;
    logic        dispatch_lhs_ready, dispatch_rhs_ready;
    logic [31:0] dispatch_lhs_val, dispatch_rhs_val;
    logic [3:0]  dispatch_lhs_tag, dispatch_rhs_tag, dispatch_tag;
    logic        rs_full;
    logic        alu_done, lsb_done;
    logic [31:0] alu_result, lsb_result;
    logic [3:0]  alu_tag, lsb_tag;
    logic        cal_signal;
    logic [3:0]  opcode, tag;
    logic [31:0] lhs, rhs;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
        .dispatch_lhs_ready(dispatch_lhs_ready), .dispatch_lhs_val(dispatch_lhs_val),
        .dispatch_lhs_tag(dispatch_lhs_tag), .dispatch_rhs_ready(dispatch_rhs_ready),
        .dispatch_rhs_val(dispatch_rhs_val), .dispatch_rhs_tag(dispatch_rhs_tag),
        .dispatch_tag(dispatch_tag), .rs_full(rs_full),
        .alu_done(alu_done), .alu_result(alu_result), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_result(lsb_result), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [3:0]  t;
    } iss_t;
    iss_t exp_q[$];

    // Reference model: an unordered bag of slots, lowest slot number wins.
    bit          m_valid [RS_N];
    logic [3:0]  m_op    [RS_N];
    bit          m_lr    [RS_N];
    logic [31:0] m_lv    [RS_N];
    logic [3:0]  m_lt    [RS_N];
    bit          m_rr    [RS_N];
    logic [31:0] m_rv    [RS_N];
    logic [3:0]  m_rt    [RS_N];
    logic [3:0]  m_dt    [RS_N];
    bit          m_cal, m_rdy_edge;
    iss_t        m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_full();
        int c = 0;
        for (int i = 0; i < RS_N; i++) if (m_valid[i]) c++;
        return c == RS_N;
    endfunction

    // Resolve a possibly-pending operand against this cycle's broadcasts.
    function automatic logic [32:0] resolve(input bit rdy, input logic [31:0] v, input logic [3:0] t);
        if (rdy) return {1'b1, v};
        if (alu_done && t == alu_tag) return {1'b1, alu_result};
        if (lsb_done && t == lsb_tag) return {1'b1, lsb_result};
        return {1'b0, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_N; i++) m_valid[i] = 1'b0;
        m_cal = 1'b0;
        m_rdy_edge = 1'b0;
        m_out = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int cnt = 0;
        int free_i = -1;
        int iss_i = -1;
        logic [32:0] res;
        for (int i = 0; i < RS_N; i++) begin
            if (m_valid[i]) cnt++;
            else if (free_i < 0) free_i = i;
            if (m_valid[i] && m_lr[i] && m_rr[i] && iss_i < 0) iss_i = i;
        end
        if (clear_signal) begin
            for (int i = 0; i < RS_N; i++) m_valid[i] = 1'b0;
            m_cal = 1'b0;
            return;
        end
        if (iss_i >= 0) begin
            m_out = '{op: m_op[iss_i], l: m_lv[iss_i], r: m_rv[iss_i], t: m_dt[iss_i]};
            exp_q.push_back(m_out);
            m_valid[iss_i] = 1'b0;
            m_cal = 1'b1;
        end else begin
            m_cal = 1'b0;
        end
        for (int i = 0; i < RS_N; i++) begin
            if (m_valid[i]) begin
                res = resolve(m_lr[i], m_lv[i], m_lt[i]); m_lr[i] = res[32]; m_lv[i] = res[31:0];
                res = resolve(m_rr[i], m_rv[i], m_rt[i]); m_rr[i] = res[32]; m_rv[i] = res[31:0];
            end
        end
        if (dispatch_valid && cnt < RS_N) begin
            m_valid[free_i] = 1'b1;
            m_op[free_i] = dispatch_opcode;
            m_dt[free_i] = dispatch_tag;
            m_lt[free_i] = dispatch_lhs_tag;
            m_rt[free_i] = dispatch_rhs_tag;
            res = resolve(dispatch_lhs_ready, dispatch_lhs_val, dispatch_lhs_tag);
            m_lr[free_i] = res[32]; m_lv[free_i] = res[31:0];
            res = resolve(dispatch_rhs_ready, dispatch_rhs_val, dispatch_rhs_tag);
            m_rr[free_i] = res[32]; m_rv[free_i] = res[31:0];
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        m_rdy_edge = rst_in && rdy_in;
        if (!rst_in) model_reset();
        else if (rdy_in) model_step();
        @(negedge clk_in);
    endtask

    task automatic idle_inputs();
        clear_signal = 1'b0; dispatch_valid = 1'b0;
        alu_done = 1'b0; lsb_done = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input bit lr, input logic [31:0] lv, input logic [3:0] lt,
                        input bit rr, input logic [31:0] rv, input logic [3:0] rt, input logic [3:0] dt);
        dispatch_valid = 1'b1; dispatch_opcode = op;
        dispatch_lhs_ready = lr; dispatch_lhs_val = lv; dispatch_lhs_tag = lt;
        dispatch_rhs_ready = rr; dispatch_rhs_val = rv; dispatch_rhs_tag = rt;
        dispatch_tag = dt;
        cycle();
        dispatch_valid = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a fresh issue.
    initial begin
        iss_t it;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                chk("cal_signal", 32'(cal_signal), 32'(m_cal));
                chk("rs_full", 32'(rs_full), 32'(m_full()));
                if (cal_signal && m_rdy_edge) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_issue: got op %0h tag %0h, expected no issue", opcode, tag);
                    end else begin
                        it = exp_q.pop_front();
                        chk("issue_opcode", 32'(opcode), 32'(it.op));
                        chk("issue_lhs", lhs, it.l);
                        chk("issue_rhs", rhs, it.r);
                        chk("issue_tag", 32'(tag), 32'(it.t));
                    end
                end else begin
                    chk("hold_opcode", 32'(opcode), 32'(m_out.op));
                    chk("hold_lhs", lhs, m_out.l);
                    chk("hold_rhs", rhs, m_out.r);
                    chk("hold_tag", 32'(tag), 32'(m_out.t));
                end
            end
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        idle_inputs();
        dispatch_opcode = 4'd0; dispatch_tag = 4'd0;
        dispatch_lhs_ready = 1'b0; dispatch_lhs_val = 32'd0; dispatch_lhs_tag = 4'd0;
        dispatch_rhs_ready = 1'b0; dispatch_rhs_val = 32'd0; dispatch_rhs_tag = 4'd0;
        alu_result = 32'd0; alu_tag = 4'd0; lsb_result = 32'd0; lsb_tag = 4'd0;
        model_reset();
        cycle(); cycle();
        rst_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_cal", 32'(cal_signal), 32'd0);
        end

        // Ready dispatch: ADD 5,7 tag 3 issues one edge later as a single pulse
        disp(4'd4, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        cycle();
        chk("add_cal", 32'(cal_signal), 32'd1);
        chk("add_opcode", 32'(opcode), 32'd4);
        chk("add_lhs", lhs, 32'd5);
        chk("add_rhs", rhs, 32'd7);
        chk("add_tag", 32'(tag), 32'd3);
        cycle();
        chk("add_pulse_end", 32'(cal_signal), 32'd0);

        // Wakeup ordering: pending SUB in slot 0, ready XOR overtakes it
        disp(4'd5, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd5);
        disp(4'd3, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd6);
        cycle();
        chk("xor_first", 32'(opcode), 32'd3);
        lsb_done = 1'b1; lsb_tag = 4'd2; lsb_result = 32'h10;
        cycle();
        lsb_done = 1'b0;
        chk("sub_not_yet", 32'(cal_signal), 32'd0);
        cycle();
        chk("sub_issue", 32'(opcode), 32'd5);
        chk("sub_lhs", lhs, 32'h10);

        // Dispatch-time forwarding from the ALU bus
        alu_done = 1'b1; alu_tag = 4'd6; alu_result = 32'hFF;
        disp(4'd1, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd6, 4'd7);
        alu_done = 1'b0;
        cycle();
        chk("fwd_cal", 32'(cal_signal), 32'd1);
        chk("fwd_rhs", rhs, 32'hFF);

        // Full: eight pending entries, ninth dispatch dropped, slot 4 recycled
        for (int i = 0; i < RS_N; i++)
            disp(4'd4, 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'(i), 4'd0, 4'(i));
        chk("full_set", 32'(rs_full), 32'd1);
        disp(4'd3, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd9);
        chk("full_ignored", 32'(rs_full), 32'd1);
        cycle();
        chk("full_no_issue", 32'(cal_signal), 32'd0);
        lsb_done = 1'b1; lsb_tag = 4'd12; lsb_result = 32'h44;
        cycle();
        lsb_done = 1'b0;
        cycle();
        chk("slot4_issue_tag", 32'(tag), 32'd4);
        chk("slot4_issue_lhs", lhs, 32'h44);
        chk("full_dropped", 32'(rs_full), 32'd0);
        disp(4'd2, 1'b0, 32'd0, 4'd13, 1'b1, 32'd2, 4'd0, 4'd8);
        chk("refill_full", 32'(rs_full), 32'd1);

        // Mid-run reset: outputs clear asynchronously
        rst_in = 1'b0;
        model_reset();
        #1;
        chk("rst_cal", 32'(cal_signal), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_lhs", lhs, 32'd0);
        chk("rst_tag", 32'(tag), 32'd0);
        chk("rst_full", 32'(rs_full), 32'd0);
        @(negedge clk_in);
        cycle();
        rst_in = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Flush with concurrent dispatch
        disp(4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd1);
        disp(4'd2, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 4'd2);
        disp(4'd3, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 4'd3);
        clear_signal = 1'b1;
        disp(4'd4, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0, 4'd4);
        clear_signal = 1'b0;
        chk("flush_cal", 32'(cal_signal), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_empty", 32'(cal_signal), 32'd0);
        end

        // Stall: rdy_in low freezes state and outputs
        disp(4'd6, 1'b1, 32'd6, 4'd0, 1'b1, 32'd1, 4'd0, 4'd10);
        disp(4'd7, 1'b1, 32'd7, 4'd0, 1'b1, 32'd2, 4'd0, 4'd11);
        dispatch_valid = 1'b1;
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_hold_cal", 32'(cal_signal), 32'd1);
            chk("stall_hold_op", 32'(opcode), 32'd6);
        end
        dispatch_valid = 1'b0;
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rdy_in = ($urandom_range(9, 0) != 0);
            clear_signal = ($urandom_range(39, 0) == 0);
            dispatch_valid = ($urandom_range(9, 0) < 6);
            dispatch_opcode = 4'($urandom_range(15, 1));
            dispatch_lhs_ready = $urandom_range(1, 0) != 0;
            dispatch_rhs_ready = $urandom_range(1, 0) != 0;
            dispatch_lhs_val = $urandom; dispatch_rhs_val = $urandom;
            dispatch_lhs_tag = 4'($urandom); dispatch_rhs_tag = 4'($urandom);
            dispatch_tag = 4'($urandom);
            alu_done = ($urandom_range(9, 0) < 4); alu_tag = 4'($urandom); alu_result = $urandom;
            lsb_done = ($urandom_range(9, 0) < 4); lsb_tag = 4'($urandom); lsb_result = $urandom;
            cycle();
        end
        idle_inputs();
        rdy_in = 1'b1;
        cycle();
        clear_signal = 1'b1;
        cycle();
        clear_signal = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
